// File: rtl/txfifo_pkg.sv
// Shared constants for the TX packet FIFO: default geometry, EOP tag position, mode encoding.
// No logic, no latency, no backpressure.
package txfifo_pkg;

    localparam int TXF_WIDTH = 64;
    localparam int TXF_DEPTH = 16;
    localparam int TXF_PTR   = 4;

    localparam int MODE_CT = 0;
    localparam int MODE_SF = 1;

    // The EOP tag rides directly above the data word in each storage entry.
    function automatic int eop_idx(input int width);
        return width;
    endfunction

endpackage

// File: rtl/txfifo_ram.sv
// Simple dual-port RAM with one write port and one registered, resettable read port.
// Read latency 1 clk; no backpressure.
module txfifo_ram
    import txfifo_pkg::*;
#(
    parameter int W     = TXF_WIDTH + 1,
    parameter int DEPTH = TXF_DEPTH,
    parameter int AW    = TXF_PTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdat <= '0;
        end else if (re) begin
            r_rdat <= r_mem[raddr];
        end
    end

    assign rdat = r_rdat;

endmodule

// File: rtl/txfifo_pkt_sync.sv
// Single-clock TX packet FIFO with EOP sideband, store-and-forward commit, abort and sticky errors.
// Read data 1 clk after an accepted rdreq; writers back off on wrfull/wralmfull.
module txfifo_pkt_sync
    import txfifo_pkg::*;
#(
    parameter int WIDTH     = TXF_WIDTH,
    parameter int DEPTH     = TXF_DEPTH,
    parameter int PTR       = TXF_PTR,
    parameter int SF_MODE   = MODE_SF,
    parameter int AF_THRESH = 12
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             wreop,
    input  logic             wrabort,
    output logic             wrfull,
    output logic             wralmfull,
    output logic [PTR:0]     wrusedw,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             rdeop,
    output logic             rdvalid,
    output logic             rdempty,
    output logic [PTR:0]     pktcnt,
    output logic             err_ovf,
    output logic             err_udf,
    output logic             err_drop
);

    localparam int         EOP = eop_idx(WIDTH);
    localparam logic [PTR:0] ONE = (PTR+1)'(1);
    localparam bit         SF  = (SF_MODE != MODE_CT);

    logic [PTR:0]     r_wptr, r_cptr, r_rptr, r_pktcnt;
    logic [DEPTH-1:0] r_eop_tag;
    logic             r_rdvalid, r_err_ovf, r_err_udf, r_err_drop;

    logic [PTR:0]   w_used;
    logic           w_full, w_empty, w_abort, w_wr_blk, w_drop, w_ovf;
    logic           w_wr_ok, w_rd_ok, w_pkt_inc, w_pkt_dec;
    logic [WIDTH:0] w_wdat, w_rdat;

    assign w_used   = r_wptr - r_rptr;
    assign w_full   = (w_used == (PTR+1)'(DEPTH));
    assign w_empty  = SF ? (r_cptr == r_rptr) : (r_wptr == r_rptr);
    assign w_abort  = SF && wrabort;
    assign w_wr_blk = wrreq && !w_abort && w_full;
    // A full FIFO with nothing committed can never drain: the packet is too big, so drop it.
    assign w_drop   = w_wr_blk && SF && (r_cptr == r_rptr);
    assign w_ovf    = w_wr_blk && !w_drop;
    assign w_wr_ok  = wrreq && !w_abort && !w_full;
    assign w_rd_ok  = rdreq && !w_empty;
    assign w_pkt_inc = w_wr_ok && wreop;
    // EOP tags are mirrored in flops so pktcnt can decrement on the read-accept edge.
    assign w_pkt_dec = w_rd_ok && r_eop_tag[r_rptr[PTR-1:0]];
    assign w_wdat    = {wreop, data};

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_wptr     <= '0;
            r_cptr     <= '0;
            r_rptr     <= '0;
            r_pktcnt   <= '0;
            r_eop_tag  <= '0;
            r_rdvalid  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_udf  <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_abort || w_drop) begin
                r_wptr <= r_cptr;
            end else if (w_wr_ok) begin
                r_wptr <= r_wptr + ONE;
            end
            if (w_wr_ok && (wreop || !SF)) begin
                r_cptr <= r_wptr + ONE;
            end
            if (w_wr_ok) begin
                r_eop_tag[r_wptr[PTR-1:0]] <= wreop;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + ONE;
            end
            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pktcnt <= r_pktcnt + ONE;
                2'b01:   r_pktcnt <= r_pktcnt - ONE;
                default: r_pktcnt <= r_pktcnt;
            endcase
            r_rdvalid <= w_rd_ok;
            if (w_ovf)             r_err_ovf  <= 1'b1;
            if (rdreq && w_empty)  r_err_udf  <= 1'b1;
            if (w_drop)            r_err_drop <= 1'b1;
        end
    end

    txfifo_ram #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PTR)
    ) u_ram (
        .clk   (clk),
        .rst   (aclr),
        .we    (w_wr_ok),
        .waddr (r_wptr[PTR-1:0]),
        .wdat  (w_wdat),
        .re    (w_rd_ok),
        .raddr (r_rptr[PTR-1:0]),
        .rdat  (w_rdat)
    );

    assign q         = w_rdat[WIDTH-1:0];
    assign rdeop     = w_rdat[EOP];
    assign rdvalid   = r_rdvalid;
    assign rdempty   = w_empty;
    assign wrfull    = w_full;
    assign wralmfull = (w_used >= (PTR+1)'(AF_THRESH));
    assign wrusedw   = w_used;
    assign pktcnt    = r_pktcnt;
    assign err_ovf   = r_err_ovf;
    assign err_udf   = r_err_udf;
    assign err_drop  = r_err_drop;

endmodule

// File: doc/txfifo_pkt_sync.md
Name: txfifo_pkt_sync

Overview:
- Single-clock TX packet FIFO; the next-generation, parametrised replacement for the dual-clock TX data FIFO on the MAC transmit path.
- Adds the following over the plain data FIFO:
  - end-of-packet sideband;
  - store-and-forward mode, where the read side sees only committed packets;
  - write-side abort, which rewinds an uncommitted packet;
  - almost-full threshold, packet count and sticky error flags.
- Sits between the host/DMA write interface and the TX framer.

Parameters:
- WIDTH, 64, data word width.
- DEPTH, 16, number of entries; must be a power of 2.
- PTR, 4, log2(DEPTH); pointers are PTR+1 bits wide.
- SF_MODE, 1, 1 = store-and-forward, 0 = cut-through.
- AF_THRESH, 12, wralmfull asserts when wrusedw >= AF_THRESH.

Ports:
- clk  in  1  single clock for the write and read sides.
- aclr  in  1  synchronous, active-high reset.
- wrreq  in  1  write request.
- data  in  WIDTH  write data.
- wreop  in  1  marks the current write word as the last word of a packet.
- wrabort  in  1  discard the uncommitted packet (effective only when SF_MODE=1).
- wrfull  out  1  FIFO full.
- wralmfull  out  1  wrusedw >= AF_THRESH.
- wrusedw  out  PTR+1  entries occupied, including uncommitted entries.
- rdreq  in  1  read request.
- q  out  WIDTH  read data, registered.
- rdeop  out  1  EOP tag of q, registered with q.
- rdvalid  out  1  q/rdeop updated this cycle.
- rdempty  out  1  no readable entry.
- pktcnt  out  PTR+1  committed packets not yet fully read.
- err_ovf  out  1  sticky: write while full.
- err_udf  out  1  sticky: read while empty.
- err_drop  out  1  sticky: oversize packet auto-dropped.

Behaviour:
- Reset (aclr=1 at a clk edge):
  - wptr, cptr, rptr and pktcnt clear to 0; q=0, rdeop=0, rdvalid=0.
  - rdempty=1; wrfull=0, wralmfull=0, wrusedw=0; all err_* flags = 0.
  - Reset overrides every request in that cycle. An uncommitted packet in flight at reset is lost.
- Storage: DEPTH x (WIDTH+1) entries; bit WIDTH holds the EOP tag.
- Pointers:
  - wptr is the write pointer, cptr the commit pointer, rptr the read pointer.
  - All are modulo 2^(PTR+1); the MSB distinguishes full from empty.
  - Only the low PTR bits address the storage.
- Status (combinational from registered pointers):
  - wrusedw = wptr - rptr; wrfull = (wrusedw == DEPTH).
  - rdempty = (cptr == rptr) when SF_MODE=1, (wptr == rptr) when SF_MODE=0.
- Write accepted when wrreq=1, wrfull=0 and wrabort=0:
  - The word is stored at wptr and wptr increments.
  - If wreop=1: cptr <= wptr+1 and pktcnt increments.
- SF_MODE=0: cptr follows wptr on every accepted write; pktcnt still counts EOP words.
- Rejected write (wrreq=1 and wrfull=1): data is discarded, err_ovf <= 1, pointers unchanged.
- Abort (SF_MODE=1, wrabort=1): wptr <= cptr and wrreq is ignored that cycle. Abort with nothing uncommitted is a no-op. In SF_MODE=0, wrabort is ignored entirely.
- Oversize packet (SF_MODE=1, wrreq=1, wrfull=1, cptr==rptr): the entire FIFO holds a single uncommitted packet.
  - wptr <= cptr and err_drop <= 1; err_ovf is not set.
  - Subsequent words of that packet are accepted as a new fragment. Upstream detects the drop via err_drop.
- Read accepted when rdreq=1 and rdempty=0:
  - Entry at rptr is registered into q/rdeop the next cycle; rdvalid=1 that cycle. Latency is 1 clk.
  - rptr increments.
  - If the entry's EOP=1, pktcnt decrements.
- Rejected read (rdreq=1 and rdempty=1): err_udf <= 1; q/rdeop hold; rdvalid=0.
- Simultaneous events:
  - Read and write in the same cycle are both evaluated against pre-cycle status.
  - Write while full is rejected even if a read occurs in that cycle.
  - Read while empty is rejected even if a write occurs; there is no fall-through.
  - pktcnt increment and decrement in the same cycle leave it unchanged.
  - Abort with a simultaneous read: both take effect.
- Wrap-around: pointers wrap naturally with no special handling; wrusedw arithmetic is modulo 2^(PTR+1).
- Sticky flags clear only on aclr.

Decomposition:
- Package txfifo_pkg holds shared constants:
  - default WIDTH/DEPTH/PTR;
  - the EOP tag bit index (WIDTH);
  - a mode encoding localparam (SF / CT).
- One sub-module, txfifo_ram: simple dual-port RAM, one write port and one registered read port, WIDTH+1 wide, DEPTH deep.
- Pointer, status and flag logic stays in txfifo_pkt_sync.

Test Plan (DEPTH=16, WIDTH=64, SF_MODE=1, AF_THRESH=12 unless noted):
- Write 4 words, EOP on the 4th:
  - rdempty stays 1 through the third write and falls the cycle after the 4th; pktcnt=1.
  - 4 reads return the words in order with rdeop=1 on the last only; pktcnt returns to 0.
- Write 3 words without EOP, then wrabort:
  - wrusedw goes 3 -> 0 and rdempty stays 1.
  - A following 2-word packet reads back correctly.
- Fill with 16 words, the last with EOP: wrfull=1 and wralmfull=1 from wrusedw=12. A 17th write sets err_ovf; the read-back is intact.
- 17 writes without EOP: on the 17th, wptr rewinds, err_drop=1, err_ovf=0, wrusedw=0.
- SF_MODE=0: a single write without EOP gives rdempty=0 the next cycle; rdreq then returns the word with rdvalid=1 one clk later.
- Wrap and boundary cases:
  - Stream 40 one-word packets with concurrent reads: no data loss, pointers wrap, pktcnt is never negative.
  - rdreq while empty sets err_udf.
  - Asserting aclr mid-stream clears all outputs on the next edge.
